pipe_ctrl_gen: RTL
==================

# pipe_ctrl_gen

Parametrised pipeline control unit: converts per-stage stall requests into a thermometer stall vector and sequences pipeline flushes with a redirect PC. It sits beside the datapath, driving the stage-boundary registers and the PC register. It adds several features to a plain stall priority encoder:
- arbitrary stage count
- registered flush with redirect PC
- flush cool-down with pending capture
- stall watchdog
- optional stall-cycle counter

## Interface
Parameters:
- STAGES, 6, number of pipeline boundaries controlled; bit 0 is the PC register.
- PC_W, 32, width of redirect PC.
- COOL_CYCLES, 2, cycles after a flush during which a new flush is deferred (≥1).
- TIMEOUT, 200, consecutive stalled cycles that trip the watchdog (≥1, < 2^16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_req  in  STAGES  bit k set = stage k requests a stall.
- flush_req  in  1  flush request (exception/redirect), sampled on clk.
- flush_pc  in  PC_W  redirect target, sampled with flush_req.
- stall  out  STAGES  bit i set = boundary i holds.
- flush  out  1  registered; clears all stage registers for one cycle.
- new_pc  out  PC_W  registered redirect target, valid while flush=1.
- wdog_err  out  1  sticky watchdog flag.
- perf_stall_cnt  out  32  stalled-cycle count (only with PIPE_CTRL_GEN_PERF_EN).

## Operation
Stall encoding (combinational):
- k = highest index with stall_req[k]=1.
- stall = (1<<(k+1))-1, i.e. bits 0..k set.
- stall = 0 when there is no request.
- stall is forced to 0 while rst=1 or state=FLUSH; flush wins over stall.

Flush FSM, states IDLE, FLUSH, COOL:
- IDLE: flush_req=1 → FLUSH; capture new_pc←flush_pc.
- FLUSH: lasts exactly one cycle, flush=1 → COOL; cool counter loaded with COOL_CYCLES-1.
- COOL: the counter decrements each cycle. At 0:
  - pending=1 → FLUSH; new_pc←pend_pc; pending cleared.
  - otherwise → IDLE.
- flush_req in FLUSH or COOL sets pending=1 and pend_pc←flush_pc; the latest request overwrites an earlier one.
- The FSM ignores stall_req.

Watchdog:
- A 16-bit counter increments each cycle stall≠0 and clears on any cycle stall=0.
- The counter saturates at TIMEOUT.
- When it reaches TIMEOUT, wdog_err is set and stays set until rst.

## Timing
- Reset values, asynchronous on rst rising:
  - stall=0, flush=0, new_pc=0, wdog_err=0, perf_stall_cnt=0.
  - state=IDLE; pending=0, pend_pc=0; watchdog count=0.
- stall: zero latency from stall_req.
- flush: flush_req high at edge N (IDLE) → flush=1 and new_pc valid during cycle N to N+1 only.
- Back-to-back flush_req while IDLE with held high:
  - flushes are at least COOL_CYCLES+1 cycles apart.
  - a request still high in the last COOL cycle is captured as pending.
- A flush_req arriving in the same cycle that COOL expires with pending=0 is captured as pending and services next; no request is lost.
- Watchdog: with TIMEOUT=T and stall held from edge 0, wdog_err rises at edge T.
- rst asserted mid-FLUSH/COOL: the pending flush is discarded and flush drops immediately.

## Configuration
- PIPE_CTRL_GEN_PERF_EN defined:
  - perf_stall_cnt exists.
  - It increments by 1 on every clk edge where stall≠0.
  - It wraps modulo 2^32.
  - It is cleared only by rst.
- Not defined: the perf_stall_cnt port and its counter are removed entirely; all other behaviour is identical.

## Test plan
- STAGES=6, stall_req=6'b000100 → stall=6'b000111; stall_req=6'b001100 → stall=6'b001111; stall_req=0 → stall=0.
- flush_req=1 with flush_pc=32'hBFC00380 for one cycle while stall_req=6'b001000 → next cycle flush=1, new_pc=32'hBFC00380, stall=0; one cycle later flush=0 and stall=6'b001111.
- COOL_CYCLES=2; flush A at edge 0, flush B (pc 32'h80000000) at edge 2 → flush high in cycles 1 and 4 only; new_pc=32'h80000000 in cycle 4.
- TIMEOUT=5; stall_req held 4 cycles, released 1 cycle, held 5 cycles → wdog_err stays 0 through the first burst and rises at the 5th edge of the second burst, then remains 1 after release.
- rst pulsed during COOL with pending=1 → no further flush afterwards; all outputs 0.
- With PIPE_CTRL_GEN_PERF_EN, 7 stalled cycles interleaved with 3 idle cycles → perf_stall_cnt=7; preload near 32'hFFFFFFFF and stall 2 cycles → value wraps to 1.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: pipeline stall/flush controller.
// Turns per-stage stall requests into a thermometer stall vector, sequences
// registered flushes with a redirect PC (with cool-down and one pending slot),
// and runs a sticky stall watchdog.
// Optional feature macro: PIPE_CTRL_GEN_PERF_EN adds the perf_stall_cnt port
// and its stalled-cycle counter.
module pipe_ctrl_gen #(
  parameter int STAGES      = 6,
  parameter int PC_W        = 32,
  parameter int COOL_CYCLES = 2,
  parameter int TIMEOUT     = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              wdog_err
`ifdef PIPE_CTRL_GEN_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, COOL} state_t;

  localparam int             CW        = $clog2(COOL_CYCLES + 1);
  localparam logic [CW-1:0]  COOL_LOAD = CW'(COOL_CYCLES - 1);
  localparam logic [15:0]    TO        = 16'(TIMEOUT);

  state_t          state;
  logic [CW-1:0]   cool_cnt;
  logic            pending;
  logic [PC_W-1:0] pend_pc;
  logic [15:0]     wd_cnt;
  logic            stalled;

  // Thermometer encode: a stall at stage k also holds every boundary below it.
  // Suppressed during reset and the flush cycle, since flush clears the stages.
  always_comb begin
    logic hit;
    hit   = 1'b0;
    stall = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hit      = hit | stall_req[i];
      stall[i] = hit;
    end
    if (rst || state == FLUSH) stall = '0;
  end

  assign stalled = (stall != '0);

  // Flush sequencer: one-cycle flush, then cool-down; requests arriving during
  // FLUSH/COOL park in a single pending slot (latest wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      flush    <= 1'b0;
      new_pc   <= '0;
      pending  <= 1'b0;
      pend_pc  <= '0;
      cool_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= flush_pc;
          end
        end
        FLUSH: begin
          state    <= COOL;
          flush    <= 1'b0;
          cool_cnt <= COOL_LOAD;
          if (flush_req) begin
            pending <= 1'b1;
            pend_pc <= flush_pc;
          end
        end
        COOL: begin
          if (cool_cnt != '0) begin
            cool_cnt <= cool_cnt - CW'(1);
            if (flush_req) begin
              pending <= 1'b1;
              pend_pc <= flush_pc;
            end
          end else if (pending) begin
            // Serve the parked request; a simultaneous new one takes the slot.
            state   <= FLUSH;
            flush   <= 1'b1;
            new_pc  <= pend_pc;
            pending <= flush_req;
            if (flush_req) pend_pc <= flush_pc;
          end else if (flush_req) begin
            // Request landing exactly at expiry is served on the next cycle.
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= flush_pc;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog: count consecutive stalled cycles (saturating), latch error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
    end else if (!stalled) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != TO) wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt >= TO - 16'd1) wdog_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_GEN_PERF_EN
  // Free-running stalled-cycle counter, wraps modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_stall_cnt <= '0;
    else if (stalled) perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule
